acm_hex_scan: RTL and testbench
===============================

Name: acm_hex_scan

Overview:
- Downstream display stage for the 6-bit accumulator.
- Captures the accumulator sum `s` each cycle, or freezes it on `hold`.
- Splits the captured value into two hex digits and time-multiplexes them onto a 2-digit active-low 7-segment display.
- Flags every change of the captured value with a one-cycle pulse for the lab board LEDs and the bench.

Parameters:
- SCAN_DIV, 4, clock cycles per digit slot (≥2; board builds override to ~100000).
- BLANK_LZ, 1, when 1 the high digit is blanked if its value is 0.

Ports:
- clock  in  1  system clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- s  in  6  accumulator sum to display
- hold  in  1  1 = freeze the captured value
- an  out  2  digit enables, active low; an[0] = low digit, an[1] = high digit
- seg  out  7  segments {g,f,e,d,c,b,a}, active low
- dp  out  1  decimal point, active low
- changed  out  1  one-cycle pulse when the captured value changes

Behaviour:
- Reset (synchronous, active-high; any cycle, including mid-scan):
  - cap=0, cnt=0, sel=0, hold_q=0.
  - Outputs: an=2'b11, seg=7'h7F, dp=1, changed=0.
- Capture:
  - When hold=0: cap<=s and changed<=(s!=cap).
  - When hold=1: cap unchanged, changed<=0.
  - hold_q<=hold every cycle.
  - Latency: s is visible on seg/an 2 cycles later (capture + output register).
- Scan counter:
  - cnt width is $clog2(SCAN_DIV).
  - If cnt==SCAN_DIV-1: cnt<=0 and sel<=~sel; otherwise cnt<=cnt+1.
  - Each digit is therefore enabled for exactly SCAN_DIV consecutive cycles, alternating forever.
- Output register (updated every non-reset cycle from current sel/cap/hold_q):
  - sel=0: an<=2'b10, seg<=enc(cap[3:0]), dp<=~hold_q.
  - sel=1: an<=2'b01, seg<=enc({2'b00,cap[5:4]}), dp<=1.
    - If BLANK_LZ=1 and cap[5:4]==0: seg<=7'h7F, and an is still driven 2'b01.
  - an never has both bits low.
- Boundaries:
  - hold asserted and released on the same value: changed=0.
  - s changing every cycle: changed high every cycle.
  - Any s value 0..63 is displayed without saturation, since all 6 bits are used.
- Hex encoding (gfedcba, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

Decomposition:
- Shared package `acm_pkg`:
  - SEG_BLANK=7'h7F.
  - Digit-enable constants AN_LO=2'b10, AN_HI=2'b01, AN_OFF=2'b11.
  - The 16-entry hex-to-segment constant table.
- One combinational sub-module `hex7seg` (4-bit in → 7-bit active-low seg), instantiated once on the muxed nibble.
- Capture, scan counter and output registers stay in the top module.

Test Plan (SCAN_DIV=4, BLANK_LZ=1):
1. Reset sequence:
   - Stimulus: reset=1 for 2 cycles, s=0, then release.
   - While reset is high: an=11, seg=7F, dp=1, changed=0.
   - First edge after release: an=10, seg=1000000, dp=1.
2. Capture and scan of 6'h2A:
   - Stimulus: s=6'h2A, hold=0.
   - changed pulses exactly one cycle.
   - Low slot: seg=0001000 (A) with an=10.
   - High slot: seg=0100100 (2) with an=01.
   - an holds each value for 4 cycles, then alternates.
3. Hold freeze and release:
   - Stimulus: hold=1, then s=6'h05 for 10 cycles.
   - Display stays 2A, changed=0, dp=0 during the an=10 slots.
   - Release hold: changed pulses once; low digit shows seg=0010010 (5).
   - High slot: an=01 with seg=7F (leading zero blanked).
4. Reset mid-scan:
   - Stimulus: assert reset for 1 cycle while sel=1 and cnt=2.
   - Next cycle: all outputs at reset values.
   - After release: scan restarts on the low digit with a full 4-cycle slot.
5. Full sweep:
   - Stimulus: s steps 0..63, one value per cycle.
   - changed=1 on every cycle after the first step.
   - cap tracks s delayed by 1 cycle.
   - At 6'h3F: low digit seg=0001110 (F), high digit seg=0110000 (3).

Source files
------------

// File: rtl/acm_pkg.sv
// acm_pkg: shared constants for the accumulator display stage.
//   SEG_BLANK          - all segments off (active low)
//   AN_LO/AN_HI/AN_OFF - active-low digit enables for low, high and no digit
//   HEX_SEG            - hex digit to {g,f,e,d,c,b,a} active-low segment table
package acm_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] AN_LO  = 2'b10;
    localparam logic [1:0] AN_HI  = 2'b01;
    localparam logic [1:0] AN_OFF = 2'b11;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex digit to 7-segment decoder.
//   i_hex  in  4  hex digit value
//   o_seg  out 7  segments {g,f,e,d,c,b,a}, active low
module hex7seg
    import acm_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_hex];

endmodule

// File: rtl/acm_hex_scan.sv
// acm_hex_scan: captures the 6-bit accumulator sum (or freezes it on hold),
// and time-multiplexes its two hex digits onto a 2-digit active-low
// 7-segment display. Flags every change of the captured value.
//   clock    in  1  system clock
//   reset    in  1  synchronous active-high reset
//   s        in  6  accumulator sum
//   hold     in  1  1 = freeze captured value
//   an       out 2  digit enables, active low (an[0] low digit, an[1] high)
//   seg      out 7  segments {g,f,e,d,c,b,a}, active low
//   dp       out 1  decimal point, active low (lit on low digit while held)
//   changed  out 1  one-cycle pulse when the captured value changes
module acm_hex_scan
    import acm_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] s,
    input  logic       hold,
    output logic [1:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       changed
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [5:0]       r_cap;
    logic             r_hold_q;
    logic             r_changed;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel;
    logic [1:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    logic [3:0] w_nib;
    logic [6:0] w_seg;
    logic       w_blank;

    // Single decoder shared by both digits; the nibble is muxed ahead of it.
    assign w_nib   = r_sel ? {2'b00, r_cap[5:4]} : r_cap[3:0];
    assign w_blank = BLANK_LZ && r_sel && (r_cap[5:4] == 2'b00);

    hex7seg u_hex7seg (
        .i_hex (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cap     <= '0;
            r_hold_q  <= 1'b0;
            r_changed <= 1'b0;
            r_cnt     <= '0;
            r_sel     <= 1'b0;
            r_an      <= AN_OFF;
            r_seg     <= SEG_BLANK;
            r_dp      <= 1'b1;
        end else begin
            r_hold_q <= hold;
            if (!hold) begin
                r_cap     <= s;
                r_changed <= (s != r_cap);
            end else begin
                r_changed <= 1'b0;
            end

            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_sel <= ~r_sel;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Output register: one cycle behind the capture register.
            // The high digit keeps its enable even when blanked so the
            // scan duty cycle stays uniform.
            r_an  <= r_sel ? AN_HI : AN_LO;
            r_seg <= w_blank ? SEG_BLANK : w_seg;
            r_dp  <= r_sel ? 1'b1 : ~r_hold_q;
        end
    end

    assign an      = r_an;
    assign seg     = r_seg;
    assign dp      = r_dp;
    assign changed = r_changed;

endmodule

// File: tb/tb_acm_hex_scan.sv
module tb_acm_hex_scan;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] s;
    logic       hold;
    logic [1:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       changed;

    int n_pass  = 0;
    int n_total = 0;
    int k       = 0;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [5:0] s;
        logic       hold;
        logic [1:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ch;
    } vec_t;

    vec_t vq[$];

    acm_hex_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clock   (clock),
        .reset   (reset),
        .s       (s),
        .hold    (hold),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .changed (changed)
    );

    always #5 clock = ~clock;

    task automatic add(input logic [5:0] sv, input logic h, input logic [1:0] a,
                       input logic [6:0] sg, input logic d, input logic c, input int n);
        for (int i = 0; i < n; i++) vq.push_back('{sv, h, a, sg, d, c});
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic check_out(input string tag, input logic [1:0] a, input logic [6:0] sg,
                             input logic d, input logic c);
        check({tag, ".an"},      int'(an),      int'(a));
        check({tag, ".seg"},     int'(seg),     int'(sg));
        check({tag, ".dp"},      int'(dp),      int'(d));
        check({tag, ".changed"}, int'(changed), int'(c));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected display of a captured value given the current scan slot.
    task automatic check_disp(input string tag, input logic [5:0] v, input int kk);
        logic       hi;
        logic [3:0] nib;
        logic [6:0] exp_seg;
        hi = (((kk - 1) / 4) % 2) == 1;
        if (hi) begin
            nib     = {2'b00, v[5:4]};
            exp_seg = (nib == 4'd0) ? 7'h7F : HEX[nib];
        end else begin
            nib     = v[3:0];
            exp_seg = HEX[nib];
        end
        check({tag, ".an"},  int'(an),  hi ? 1 : 2);
        check({tag, ".seg"}, int'(seg), int'(exp_seg));
        check({tag, ".dp"},  int'(dp),  1);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        s     = 6'h00;
        hold  = 1'b0;

        // Capture/scan of 2A, hold freeze, release to 05, then up to mid-scan.
        add(6'h2A, 1'b0, 2'b10, 7'h40, 1'b1, 1'b1, 1);
        add(6'h2A, 1'b0, 2'b10, 7'h08, 1'b1, 1'b0, 2);
        add(6'h2A, 1'b0, 2'b01, 7'h24, 1'b1, 1'b0, 4);
        add(6'h2A, 1'b0, 2'b10, 7'h08, 1'b1, 1'b0, 4);
        add(6'h05, 1'b1, 2'b01, 7'h24, 1'b1, 1'b0, 4);
        add(6'h05, 1'b1, 2'b10, 7'h08, 1'b0, 1'b0, 4);
        add(6'h05, 1'b1, 2'b01, 7'h24, 1'b1, 1'b0, 2);
        add(6'h05, 1'b0, 2'b01, 7'h24, 1'b1, 1'b1, 1);
        add(6'h05, 1'b0, 2'b01, 7'h7F, 1'b1, 1'b0, 1);
        add(6'h05, 1'b0, 2'b10, 7'h12, 1'b1, 1'b0, 4);
        add(6'h05, 1'b0, 2'b01, 7'h7F, 1'b1, 1'b0, 2);

        // Reset sequence
        tick();
        check_out("rst0", 2'b11, 7'h7F, 1'b1, 1'b0);
        tick();
        check_out("rst1", 2'b11, 7'h7F, 1'b1, 1'b0);
        reset = 1'b0;
        tick();
        check_out("post_rst", 2'b10, 7'h40, 1'b1, 1'b0);

        // Table-driven vectors
        for (int i = 0; i < vq.size(); i++) begin
            s    = vq[i].s;
            hold = vq[i].hold;
            tick();
            check_out($sformatf("vec%0d", i), vq[i].an, vq[i].seg, vq[i].dp, vq[i].ch);
        end

        // Reset mid-scan (sel=1, cnt=2 at this point)
        reset = 1'b1;
        tick();
        check_out("midrst", 2'b11, 7'h7F, 1'b1, 1'b0);
        reset = 1'b0;
        for (int r = 1; r <= 5; r++) begin
            tick();
            check_out($sformatf("restart%0d", r),
                      (r <= 4) ? 2'b10 : 2'b01,
                      (r == 1) ? 7'h40 : ((r <= 4) ? 7'h12 : 7'h7F),
                      1'b1,
                      (r == 1) ? 1'b1 : 1'b0);
        end
        k = 5;

        // Full sweep 0..63, one value per cycle
        for (int j = 0; j < 64; j++) begin
            s = 6'(j);
            tick();
            k++;
            if (j >= 1) begin
                check($sformatf("sweep%0d.changed", j), int'(changed), 1);
                check_disp($sformatf("sweep%0d", j), 6'(j - 1), k);
            end
        end
        for (int t = 0; t < 9; t++) begin
            tick();
            k++;
            check_disp($sformatf("hold3F_%0d", t), 6'h3F, k);
            check($sformatf("hold3F_%0d.changed", t), int'(changed), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
